// File: rtl/video_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_sync_gen
// Description : Raster timing generator with h/v position counters decoded into
//               registered sync, blank and line/frame markers; 2:1 interlace.
// Revision    : 1.0 - initial release
// ============================================================================
module video_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int SYNC_POL = 1
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          en,
    input  logic          interlace,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync,
    output logic          vsync,
    output logic          csync,
    output logic          cblank,
    output logic          field,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_HALF  = c_H_TOTAL / 2;
    localparam int c_VS0     = V_ACTIVE + V_FP;

    // One spare bit on every compare constant so boundaries equal to the
    // total (zero-width porches) still fit.
    localparam logic [HW:0] c_H_LAST   = (HW+1)'(c_H_TOTAL - 1);
    localparam logic [HW:0] c_H_ACT    = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] c_HS_BEG   = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] c_HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW:0] c_H_MID    = (HW+1)'(c_H_HALF);
    localparam logic [VW:0] c_V_LAST_S = (VW+1)'(c_V_TOTAL - 1);
    localparam logic [VW:0] c_V_LAST_L = (VW+1)'(c_V_TOTAL);
    localparam logic [VW:0] c_V_ACT    = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] c_VS_BEG   = (VW+1)'(c_VS0);
    localparam logic [VW:0] c_VS_END   = (VW+1)'(c_VS0 + V_SYNC);
    localparam logic        c_POL      = (SYNC_POL != 0);
    localparam logic        c_HAS_VS   = (V_SYNC > 0);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_field;
    logic          r_mode;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_csync;
    logic          r_cblank;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_mode_nxt;
    logic          w_field_nxt;
    logic [HW:0]   w_hx;
    logic [VW:0]   w_vx;
    logic          w_hs_act;
    logic          w_vs_prog;
    logic          w_vs_half;
    logic          w_vs_act;
    logic          w_cb;

    // Next position and field bookkeeping.
    always_comb begin
        w_h_wrap    = ({1'b0, r_hcnt} == c_H_LAST);
        w_v_wrap    = w_h_wrap &&
                      ({1'b0, r_vcnt} == ((r_mode && r_field) ? c_V_LAST_L : c_V_LAST_S));
        w_h_nxt     = w_h_wrap ? '0 : r_hcnt + HW'(1);
        w_v_nxt     = w_v_wrap ? '0 : (w_h_wrap ? r_vcnt + VW'(1) : r_vcnt);
        w_mode_nxt  = w_v_wrap ? interlace : r_mode;
        w_field_nxt = w_v_wrap ? (interlace & ~r_field) : r_field;
    end

    // Decode the position about to be loaded so outputs line up with counters.
    always_comb begin
        w_hx      = {1'b0, w_h_nxt};
        w_vx      = {1'b0, w_v_nxt};
        w_hs_act  = (w_hx >= c_HS_BEG) && (w_hx < c_HS_END);
        w_vs_prog = (w_vx >= c_VS_BEG) && (w_vx < c_VS_END);
        w_vs_half = c_HAS_VS &&
                    (((w_vx == c_VS_BEG) && (w_hx >= c_H_MID)) ||
                     ((w_vx >  c_VS_BEG) && (w_vx <  c_VS_END)) ||
                     ((w_vx == c_VS_END) && (w_hx <  c_H_MID)));
        w_vs_act  = w_field_nxt ? w_vs_half : w_vs_prog;
        w_cb      = (w_hx >= c_H_ACT) || (w_vx >= c_V_ACT);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_field       <= 1'b0;
            r_mode        <= 1'b0;
            r_hsync       <= ~c_POL;
            r_vsync       <= ~c_POL;
            r_csync       <= ~c_POL;
            r_cblank      <= 1'b0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else if (en) begin
            r_hcnt        <= w_h_nxt;
            r_vcnt        <= w_v_nxt;
            r_field       <= w_field_nxt;
            r_mode        <= w_mode_nxt;
            r_hsync       <= w_hs_act ? c_POL : ~c_POL;
            r_vsync       <= w_vs_act ? c_POL : ~c_POL;
            r_csync       <= (w_hs_act ^ w_vs_act) ? c_POL : ~c_POL;
            r_cblank      <= w_cb;
            r_line_start  <= (w_h_nxt == '0);
            r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign csync       = r_csync;
    assign cblank      = r_cblank;
    assign field       = r_field;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
